fm_arbiter: RTL

FM_ARBITER -- requirements
Module: fm_arbiter

---
 rtl/fm_arbiter_if.sv | 50 +++++
 rtl/fm_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fm_arbiter_if.sv
// Bundle of the two client ports (conv, pool) and the feature-map memory port.
// The slave modport is the arbiter's view; the master modport is the clients/memory view.
interface fm_arbiter_if #(
    parameter int COORD_BITS = 5,
    parameter int FM_BITS    = 32,
    parameter int ADDR_BITS  = 10
);
    logic [2*COORD_BITS-1:0] conv_coord_get;
    logic                    conv_read_req;
    logic                    conv_read_ready;
    logic [FM_BITS-1:0]      conv_data_out;
    logic [2*COORD_BITS-1:0] conv_coord_wtr;
    logic [FM_BITS-1:0]      conv_data_in;
    logic                    conv_write_req;
    logic                    conv_write_ready;

    logic [2*COORD_BITS-1:0] pool_coord_get;
    logic                    pool_read_req;
    logic                    pool_read_ready;
    logic [FM_BITS-1:0]      pool_data_out;
    logic [2*COORD_BITS-1:0] pool_coord_wtr;
    logic [FM_BITS-1:0]      pool_data_in;
    logic                    pool_write_req;
    logic                    pool_write_ready;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_BITS-1:0]    mem_addr;
    logic [FM_BITS-1:0]      mem_wdata;
    logic [FM_BITS-1:0]      mem_rdata;
    logic                    coord_err;

    modport master (
        output conv_coord_get, conv_read_req, conv_coord_wtr, conv_data_in, conv_write_req,
        input  conv_read_ready, conv_data_out, conv_write_ready,
        output pool_coord_get, pool_read_req, pool_coord_wtr, pool_data_in, pool_write_req,
        input  pool_read_ready, pool_data_out, pool_write_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, coord_err,
        output mem_rdata
    );

    modport slave (
        input  conv_coord_get, conv_read_req, conv_coord_wtr, conv_data_in, conv_write_req,
        output conv_read_ready, conv_data_out, conv_write_ready,
        input  pool_coord_get, pool_read_req, pool_coord_wtr, pool_data_in, pool_write_req,
        output pool_read_ready, pool_data_out, pool_write_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, coord_err,
        input  mem_rdata
    );
endinterface

// File: rtl/fm_arbiter.sv
// Round-robin arbiter giving the conv and pool clients single-word read/write
// access to one feature-map memory with a one-cycle read latency.
module fm_arbiter #(
    parameter int COORD_BITS       = 5,
    parameter int IMG_WIDTH        = 32,
    parameter int IMG_HEIGHT       = 32,
    parameter int CHANNELS         = 4,
    parameter int BITS_PER_CHANNEL = 8,
    localparam int FM_BITS         = CHANNELS * BITS_PER_CHANNEL,
    localparam int ADDR_BITS       = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input logic         clk,
    input logic         rst,
    fm_arbiter_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state, state_nxt;
    logic                 pool_next, pool_next_nxt;
    logic                 sel_pool, sel_pool_nxt;
    logic                 is_wr, is_wr_nxt;
    logic                 in_range, in_range_nxt;

    logic                 mem_en, mem_en_nxt;
    logic                 mem_we, mem_we_nxt;
    logic [ADDR_BITS-1:0] mem_addr, mem_addr_nxt;
    logic [FM_BITS-1:0]   mem_wdata, mem_wdata_nxt;
    logic                 conv_wr_rdy, conv_wr_rdy_nxt;
    logic                 pool_wr_rdy, pool_wr_rdy_nxt;
    logic                 conv_rd_rdy, conv_rd_rdy_nxt;
    logic                 pool_rd_rdy, pool_rd_rdy_nxt;
    logic [FM_BITS-1:0]   conv_dout, conv_dout_nxt;
    logic [FM_BITS-1:0]   pool_dout, pool_dout_nxt;
    logic                 coord_err, coord_err_nxt;

    logic                    conv_any, pool_any, grant_pool, wr, ok;
    logic [2*COORD_BITS-1:0] coord;
    logic [COORD_BITS-1:0]   cy, cx;
    logic [FM_BITS-1:0]      rd_word;

    function automatic logic coord_ok(input logic [COORD_BITS-1:0] y, input logic [COORD_BITS-1:0] x);
        return (int'(x) < IMG_WIDTH) && (int'(y) < IMG_HEIGHT);
    endfunction

    // Full-width linear address; the caller truncates to ADDR_BITS.
    function automatic logic [31:0] calc_addr(input logic [COORD_BITS-1:0] y, input logic [COORD_BITS-1:0] x);
        return 32'(y) * 32'(IMG_WIDTH) + 32'(x);
    endfunction

    always_comb begin
        state_nxt       = state;
        pool_next_nxt   = pool_next;
        sel_pool_nxt    = sel_pool;
        is_wr_nxt       = is_wr;
        in_range_nxt    = in_range;
        mem_en_nxt      = 1'b0;
        mem_we_nxt      = 1'b0;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        conv_wr_rdy_nxt = 1'b0;
        pool_wr_rdy_nxt = 1'b0;
        conv_rd_rdy_nxt = 1'b0;
        pool_rd_rdy_nxt = 1'b0;
        conv_dout_nxt   = conv_dout;
        pool_dout_nxt   = pool_dout;
        coord_err_nxt   = coord_err;
        conv_any        = bus.conv_read_req | bus.conv_write_req;
        pool_any        = bus.pool_read_req | bus.pool_write_req;
        grant_pool      = pool_any && (!conv_any || pool_next);
        wr              = grant_pool ? bus.pool_write_req : bus.conv_write_req;
        coord           = grant_pool ? (wr ? bus.pool_coord_wtr : bus.pool_coord_get)
                                     : (wr ? bus.conv_coord_wtr : bus.conv_coord_get);
        cy              = coord[2*COORD_BITS-1:COORD_BITS];
        cx              = coord[COORD_BITS-1:0];
        ok              = coord_ok(cy, cx);
        rd_word         = in_range ? bus.mem_rdata : '0;

        unique case (state)
            S_IDLE: begin
                if (conv_any || pool_any) begin
                    // Everything the transaction needs is captured here; inputs are ignored afterwards.
                    state_nxt       = S_ISSUE;
                    pool_next_nxt   = !grant_pool;
                    sel_pool_nxt    = grant_pool;
                    is_wr_nxt       = wr;
                    in_range_nxt    = ok;
                    mem_en_nxt      = ok;
                    mem_we_nxt      = ok && wr;
                    mem_addr_nxt    = ADDR_BITS'(calc_addr(cy, cx));
                    coord_err_nxt   = coord_err | !ok;
                    conv_wr_rdy_nxt = wr && !grant_pool;
                    pool_wr_rdy_nxt = wr && grant_pool;
                    if (wr) begin
                        mem_wdata_nxt = grant_pool ? bus.pool_data_in : bus.conv_data_in;
                    end
                end
            end
            S_ISSUE: state_nxt = is_wr ? S_IDLE : S_WAIT;
            S_WAIT: begin
                state_nxt = S_RESP;
                if (sel_pool) begin
                    pool_dout_nxt   = rd_word;
                    pool_rd_rdy_nxt = 1'b1;
                end else begin
                    conv_dout_nxt   = rd_word;
                    conv_rd_rdy_nxt = 1'b1;
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pool_next   <= 1'b0;
            sel_pool    <= 1'b0;
            is_wr       <= 1'b0;
            in_range    <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            conv_wr_rdy <= 1'b0;
            pool_wr_rdy <= 1'b0;
            conv_rd_rdy <= 1'b0;
            pool_rd_rdy <= 1'b0;
            conv_dout   <= '0;
            pool_dout   <= '0;
            coord_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pool_next   <= pool_next_nxt;
            sel_pool    <= sel_pool_nxt;
            is_wr       <= is_wr_nxt;
            in_range    <= in_range_nxt;
            mem_en      <= mem_en_nxt;
            mem_we      <= mem_we_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            conv_wr_rdy <= conv_wr_rdy_nxt;
            pool_wr_rdy <= pool_wr_rdy_nxt;
            conv_rd_rdy <= conv_rd_rdy_nxt;
            pool_rd_rdy <= pool_rd_rdy_nxt;
            conv_dout   <= conv_dout_nxt;
            pool_dout   <= pool_dout_nxt;
            coord_err   <= coord_err_nxt;
        end
    end

    assign bus.mem_en           = mem_en;
    assign bus.mem_we           = mem_we;
    assign bus.mem_addr         = mem_addr;
    assign bus.mem_wdata        = mem_wdata;
    assign bus.conv_write_ready = conv_wr_rdy;
    assign bus.pool_write_ready = pool_wr_rdy;
    assign bus.conv_read_ready  = conv_rd_rdy;
    assign bus.pool_read_ready  = pool_rd_rdy;
    assign bus.conv_data_out    = conv_dout;
    assign bus.pool_data_out    = pool_dout;
    assign bus.coord_err        = coord_err;

endmodule
